// File: rtl/skin_bbox_detect_if.sv
// Camera pixel stream into the skin detector, classified stream and per-frame box out.
interface skin_bbox_detect_if;
   logic        cmos_frame_vsync;
   logic        cmos_frame_href;
   logic        cmos_frame_valid;
   logic [15:0] cmos_frame_data;
   logic        skin_vsync;
   logic        skin_href;
   logic        skin_valid;
   logic        skin_bit;
   logic [10:0] pix_x;
   logic [10:0] pix_y;
   logic [10:0] bbox_x_min;
   logic [10:0] bbox_x_max;
   logic [10:0] bbox_y_min;
   logic [10:0] bbox_y_max;
   logic [19:0] bbox_cnt;
   logic        bbox_found;
   logic        bbox_valid;

   modport master (
      output cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data,
      input  skin_vsync, skin_href, skin_valid, skin_bit, pix_x, pix_y,
      input  bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_cnt, bbox_found, bbox_valid
   );

   modport slave (
      input  cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data,
      output skin_vsync, skin_href, skin_valid, skin_bit, pix_x, pix_y,
      output bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_cnt, bbox_found, bbox_valid
   );
endinterface

// File: rtl/skin_bbox_detect.sv
// RGB565 -> Cb/Cr skin classifier with per-frame skin bounding box and count.
// Fixed 3-cycle pipeline, no stall/backpressure; box latches one cycle after delayed vsync rises.
module skin_bbox_detect #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int CB_MIN     = 77,
   parameter int CB_MAX     = 127,
   parameter int CR_MIN     = 133,
   parameter int CR_MAX     = 173,
   parameter int MIN_PIXELS = 256
) (
   input  logic              cam_pclk,
   input  logic              rst,
   skin_bbox_detect_if.slave bus
);
   localparam logic [10:0] L_IMG_W   = 11'(IMG_W);
   localparam logic [10:0] L_IMG_H   = 11'(IMG_H);
   localparam logic [7:0]  L_CB_MIN  = 8'(CB_MIN);
   localparam logic [7:0]  L_CB_MAX  = 8'(CB_MAX);
   localparam logic [7:0]  L_CR_MIN  = 8'(CR_MIN);
   localparam logic [7:0]  L_CR_MAX  = 8'(CR_MAX);
   localparam logic [19:0] L_MIN_PIX = 20'(MIN_PIXELS);
   localparam logic [10:0] L_CMAX    = 11'h7FF;
   localparam logic [19:0] L_NMAX    = 20'hFFFFF;

   logic [7:0]  w_r8, w_g8, w_b8;
   logic        w_vsync_rise, w_href_fall;
   logic        r_vsync_d, r_href_d;
   logic [10:0] r_x, r_y;

   logic [15:0] r_s1_r43, r_s1_g85, r_s1_b21, r_s1_g107, r_s1_r128, r_s1_b128;
   logic        r_s1_vs, r_s1_hr, r_s1_vl;
   logic [10:0] r_s1_x, r_s1_y;
   logic signed [16:0] w_cb_sum, w_cr_sum;
   logic [7:0]  r_s2_cb, r_s2_cr;
   logic        r_s2_vs, r_s2_hr, r_s2_vl;
   logic [10:0] r_s2_x, r_s2_y;
   logic        r_s3_skin, r_s3_vs, r_s3_hr, r_s3_vl;
   logic [10:0] r_s3_x, r_s3_y;

   assign w_r8 = {bus.cmos_frame_data[15:11], bus.cmos_frame_data[15:13]};
   assign w_g8 = {bus.cmos_frame_data[10:5],  bus.cmos_frame_data[10:9]};
   assign w_b8 = {bus.cmos_frame_data[4:0],   bus.cmos_frame_data[4:2]};

   assign w_vsync_rise = bus.cmos_frame_vsync & ~r_vsync_d;
   assign w_href_fall  = ~bus.cmos_frame_href & r_href_d;

   assign w_cb_sum = 17'sd32768 - $signed({1'b0, r_s1_r43}) - $signed({1'b0, r_s1_g85})
                   + $signed({1'b0, r_s1_b128});
   assign w_cr_sum = 17'sd32768 + $signed({1'b0, r_s1_r128}) - $signed({1'b0, r_s1_g107})
                   - $signed({1'b0, r_s1_b21});

   always_ff @(posedge cam_pclk or posedge rst) begin
      if (rst) begin
         r_vsync_d <= 1'b0;  r_href_d <= 1'b0;
         r_x       <= '0;    r_y      <= '0;
         r_s1_r43  <= '0;    r_s1_g85 <= '0;  r_s1_b21  <= '0;
         r_s1_g107 <= '0;    r_s1_r128 <= '0; r_s1_b128 <= '0;
         r_s1_vs   <= 1'b0;  r_s1_hr  <= 1'b0; r_s1_vl  <= 1'b0;
         r_s1_x    <= '0;    r_s1_y   <= '0;
         r_s2_cb   <= '0;    r_s2_cr  <= '0;
         r_s2_vs   <= 1'b0;  r_s2_hr  <= 1'b0; r_s2_vl  <= 1'b0;
         r_s2_x    <= '0;    r_s2_y   <= '0;
         r_s3_skin <= 1'b0;  r_s3_vs  <= 1'b0; r_s3_hr  <= 1'b0; r_s3_vl <= 1'b0;
         r_s3_x    <= '0;    r_s3_y   <= '0;
      end else begin
         r_vsync_d <= bus.cmos_frame_vsync;
         r_href_d  <= bus.cmos_frame_href;
         if (!bus.cmos_frame_href)
            r_x <= '0;
         else if (bus.cmos_frame_valid && r_x != L_CMAX)
            r_x <= r_x + 11'd1;
         // r_x still holds the line's pixel count on the href falling edge
         if (w_vsync_rise)
            r_y <= '0;
         else if (w_href_fall && r_x != 11'd0 && r_y != L_CMAX)
            r_y <= r_y + 11'd1;

         r_s1_r43  <= 16'(w_r8) * 16'd43;
         r_s1_g85  <= 16'(w_g8) * 16'd85;
         r_s1_b21  <= 16'(w_b8) * 16'd21;
         r_s1_g107 <= 16'(w_g8) * 16'd107;
         r_s1_r128 <= {1'b0, w_r8, 7'd0};
         r_s1_b128 <= {1'b0, w_b8, 7'd0};
         r_s1_vs   <= bus.cmos_frame_vsync;
         r_s1_hr   <= bus.cmos_frame_href;
         r_s1_vl   <= bus.cmos_frame_valid;
         r_s1_x    <= r_x;
         r_s1_y    <= r_y;

         r_s2_cb <= 8'(w_cb_sum >>> 8);
         r_s2_cr <= 8'(w_cr_sum >>> 8);
         r_s2_vs <= r_s1_vs;  r_s2_hr <= r_s1_hr;  r_s2_vl <= r_s1_vl;
         r_s2_x  <= r_s1_x;   r_s2_y  <= r_s1_y;

         r_s3_skin <= (r_s2_cb >= L_CB_MIN) && (r_s2_cb <= L_CB_MAX) &&
                      (r_s2_cr >= L_CR_MIN) && (r_s2_cr <= L_CR_MAX);
         r_s3_vs <= r_s2_vs;  r_s3_hr <= r_s2_hr;  r_s3_vl <= r_s2_vl;
         r_s3_x  <= r_s2_x;   r_s3_y  <= r_s2_y;
      end
   end

   logic        r_vs3_d, r_active, r_bvld, r_bfound;
   logic [10:0] r_xmin, r_xmax, r_ymin, r_ymax;
   logic [10:0] r_bx_min, r_bx_max, r_by_min, r_by_max;
   logic [19:0] r_cnt, r_bcnt;
   logic        w_close, w_hit, w_active_nxt;
   logic [10:0] w_xmin_nxt, w_xmax_nxt, w_ymin_nxt, w_ymax_nxt;
   logic [19:0] w_cnt_nxt;

   assign w_close      = r_s3_vs & ~r_vs3_d;
   assign w_hit        = r_s3_vl & r_s3_skin & (r_s3_x < L_IMG_W) & (r_s3_y < L_IMG_H);
   assign w_active_nxt = r_active | r_s3_vl;

   // Next-values include the stage-3 pixel so one coincident with the close is counted
   always_comb begin
      w_xmin_nxt = r_xmin;
      w_xmax_nxt = r_xmax;
      w_ymin_nxt = r_ymin;
      w_ymax_nxt = r_ymax;
      w_cnt_nxt  = r_cnt;
      if (w_hit) begin
         if (r_s3_x < r_xmin) w_xmin_nxt = r_s3_x;
         if (r_s3_x > r_xmax) w_xmax_nxt = r_s3_x;
         if (r_s3_y < r_ymin) w_ymin_nxt = r_s3_y;
         if (r_s3_y > r_ymax) w_ymax_nxt = r_s3_y;
         if (r_cnt != L_NMAX) w_cnt_nxt = r_cnt + 20'd1;
      end
   end

   always_ff @(posedge cam_pclk or posedge rst) begin
      if (rst) begin
         r_vs3_d  <= 1'b0;   r_active <= 1'b0;  r_bvld <= 1'b0;
         r_xmin   <= L_CMAX; r_xmax   <= '0;
         r_ymin   <= L_CMAX; r_ymax   <= '0;
         r_cnt    <= '0;
         r_bx_min <= '0;     r_bx_max <= '0;
         r_by_min <= '0;     r_by_max <= '0;
         r_bcnt   <= '0;     r_bfound <= 1'b0;
      end else begin
         r_vs3_d <= r_s3_vs;
         r_bvld  <= w_close & w_active_nxt;
         if (w_close) begin
            if (w_active_nxt) begin
               if (w_cnt_nxt == 20'd0) begin
                  r_bx_min <= '0;  r_bx_max <= '0;
                  r_by_min <= '0;  r_by_max <= '0;
               end else begin
                  r_bx_min <= w_xmin_nxt;  r_bx_max <= w_xmax_nxt;
                  r_by_min <= w_ymin_nxt;  r_by_max <= w_ymax_nxt;
               end
               r_bcnt   <= w_cnt_nxt;
               r_bfound <= (w_cnt_nxt >= L_MIN_PIX);
            end
            r_xmin   <= L_CMAX;  r_xmax <= '0;
            r_ymin   <= L_CMAX;  r_ymax <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
         end else begin
            r_xmin   <= w_xmin_nxt;  r_xmax <= w_xmax_nxt;
            r_ymin   <= w_ymin_nxt;  r_ymax <= w_ymax_nxt;
            r_cnt    <= w_cnt_nxt;
            r_active <= w_active_nxt;
         end
      end
   end

   assign bus.skin_vsync = r_s3_vs;
   assign bus.skin_href  = r_s3_hr;
   assign bus.skin_valid = r_s3_vl;
   assign bus.skin_bit   = r_s3_skin;
   assign bus.pix_x      = r_s3_x;
   assign bus.pix_y      = r_s3_y;
   assign bus.bbox_x_min = r_bx_min;
   assign bus.bbox_x_max = r_bx_max;
   assign bus.bbox_y_min = r_by_min;
   assign bus.bbox_y_max = r_by_max;
   assign bus.bbox_cnt   = r_bcnt;
   assign bus.bbox_found = r_bfound;
   assign bus.bbox_valid = r_bvld;
endmodule
